// File: rtl/debug_step_ctrl.sv
// rtl/debug_step_ctrl.sv - UART debug controller gating MIPS pipeline clock enable and reset
module debug_step_ctrl #(
    parameter logic [7:0] CMD_STEP     = 8'h31,
    parameter logic [7:0] CMD_RUN      = 8'h32,
    parameter logic [7:0] CMD_RESET    = 8'h33,
    parameter logic [7:0] CMD_STEPN    = 8'h34,
    parameter int         RESET_CYCLES = 2,
    parameter int         RUN_LIMIT    = 1024,
    parameter int         CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       r_data,
    input  logic             rx_ready,
    output logic             rd_uart,
    input  logic             dataSent,
    output logic             sendSignal,
    input  logic             program_finished,
    output logic             pipelineClkEn,
    output logic             pipelineReset,
    output logic [2:0]       current_state,
    output logic [7:0]       status,
    output logic [CNT_W-1:0] cycle_count
);

    // Shared down/up counter must cover the run limit, the reset length and an 8-bit N.
    localparam int MAX_A = (RUN_LIMIT > 255) ? RUN_LIMIT : 255;
    localparam int MAXC  = (MAX_A > RESET_CYCLES) ? MAX_A : RESET_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0] RST_C    = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] RST_C_M1 = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] RUN_C    = CW'(RUN_LIMIT);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_SENDING = 3'd2,
        S_ARG     = 3'd3,
        S_EXEC    = 3'd4,
        S_SWRESET = 3'd5,
        S_ACK     = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             arg_q, arg_d;
    logic             run_q, run_d;
    logic             en_q, en_d;
    logic             prst_q, prst_d;
    logic             rd_q, rd_d;
    logic             send_q, send_d;
    logic [7:0]       status_q, status_d;
    logic [CNT_W-1:0] cc_q, cc_d;
    logic [CNT_W-1:0] cc_inc;
    logic             go_exec;
    logic [CW-1:0]    load_v;

    assign cc_inc = (&cc_q) ? cc_q : cc_q + 1'b1;

    // Next-state and registered-output decode; outputs are computed for the cycle being entered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        arg_d    = arg_q;
        run_d    = run_q;
        en_d     = 1'b0;
        prst_d   = 1'b0;
        rd_d     = 1'b0;
        send_d   = 1'b0;
        status_d = status_q;
        cc_d     = cc_q;
        go_exec  = 1'b0;
        load_v   = '0;

        case (state_q)
            S_INIT: begin
                if (cnt_q < RST_C) begin
                    en_d   = 1'b1;
                    prst_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (rx_ready) begin
                    byte_d  = r_data;
                    arg_d   = 1'b0;
                    rd_d    = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ARG: begin
                if (rx_ready) begin
                    byte_d  = r_data;
                    arg_d   = 1'b1;
                    rd_d    = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                run_d = 1'b0;
                if (arg_q) begin
                    if (byte_q == 8'h00) begin
                        status_d = 8'h00;
                        send_d   = 1'b1;
                        state_d  = S_SENDING;
                    end else begin
                        go_exec = 1'b1;
                        load_v  = CW'(byte_q);
                    end
                end else if (byte_q == CMD_STEP) begin
                    go_exec = 1'b1;
                    load_v  = CW'(1);
                end else if (byte_q == CMD_RUN) begin
                    go_exec = 1'b1;
                    load_v  = RUN_C;
                    run_d   = 1'b1;
                end else if (byte_q == CMD_RESET) begin
                    en_d    = 1'b1;
                    prst_d  = 1'b1;
                    cnt_d   = RST_C_M1;
                    state_d = S_SWRESET;
                end else if (byte_q == CMD_STEPN) begin
                    state_d = S_ARG;
                end else begin
                    status_d = 8'hFF;
                    send_d   = 1'b1;
                    state_d  = S_SENDING;
                end
            end
            S_EXEC: begin
                // Budget exhaustion wins over a finish seen after the last enabled cycle.
                if (cnt_q == '0) begin
                    status_d = run_q ? 8'h02 : 8'h00;
                    send_d   = 1'b1;
                    state_d  = S_SENDING;
                end else if (program_finished) begin
                    status_d = 8'h01;
                    send_d   = 1'b1;
                    state_d  = S_SENDING;
                end else begin
                    en_d  = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    cc_d  = cc_inc;
                end
            end
            S_SWRESET: begin
                if (cnt_q == '0) begin
                    cc_d     = '0;
                    status_d = 8'h00;
                    send_d   = 1'b1;
                    state_d  = S_SENDING;
                end else begin
                    en_d   = 1'b1;
                    prst_d = 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                end
            end
            S_SENDING: begin
                if (dataSent) begin
                    state_d = S_IDLE;
                end else begin
                    send_d = 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // Entering EXEC issues the first enable immediately unless the program already ended.
        if (go_exec) begin
            state_d = S_EXEC;
            if (program_finished) begin
                cnt_d = load_v;
            end else begin
                en_d  = 1'b1;
                cnt_d = load_v - 1'b1;
                cc_d  = cc_inc;
            end
        end
    end

    // State and output registers with asynchronous active-low reset to INIT values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            byte_q   <= '0;
            arg_q    <= 1'b0;
            run_q    <= 1'b0;
            en_q     <= 1'b0;
            prst_q   <= 1'b1;
            rd_q     <= 1'b0;
            send_q   <= 1'b0;
            status_q <= '0;
            cc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            arg_q    <= arg_d;
            run_q    <= run_d;
            en_q     <= en_d;
            prst_q   <= prst_d;
            rd_q     <= rd_d;
            send_q   <= send_d;
            status_q <= status_d;
            cc_q     <= cc_d;
        end
    end

    assign rd_uart       = rd_q;
    assign sendSignal    = send_q;
    assign pipelineClkEn = en_q;
    assign pipelineReset = prst_q;
    assign current_state = state_q;
    assign status        = status_q;
    assign cycle_count   = cc_q;

endmodule

// File: doc/debug_step_ctrl.md
# debug_step_ctrl

Parametrised UART debug controller that sits between the UART receive/transmit FIFOs and the MIPS pipeline. It decodes command bytes, gates the pipeline with a clock enable (single step, N-step, run-to-finish with a cycle limit) and drives the pipeline reset (hardware reset and timed software reset). After every command it asks the transmit side to send the debug dump and holds the request until the send completes. It adds a running pipeline-cycle counter and a status byte for the host.

## Interface
Parameters:
- CMD_STEP, 8'h31: ASCII '1', one pipeline cycle.
- CMD_RUN, 8'h32: ASCII '2', run until program_finished or RUN_LIMIT.
- CMD_RESET, 8'h33: ASCII '3', software reset.
- CMD_STEPN, 8'h34: ASCII '4', the next byte N gives the number of cycles.
- RESET_CYCLES, 2: cycles of pipelineReset=1 with enable=1 (≥1).
- RUN_LIMIT, 1024: maximum enabled cycles per RUN command (≥1).
- CNT_W, 16: width of cycle_count.

Ports (one clock; reset is asynchronous and active-low):
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-low (0 = reset).
- r_data, in, 8: RX FIFO head byte.
- rx_ready, in, 1: RX FIFO not empty.
- rd_uart, out, 1: one-cycle RX FIFO pop.
- dataSent, in, 1: transmit side finished the dump.
- sendSignal, out, 1: dump request.
- program_finished, in, 1: pipeline reached its end.
- pipelineClkEn, out, 1: pipeline clock enable (registered; no gated clock).
- pipelineReset, out, 1: pipeline synchronous reset.
- current_state, out, 3: state code.
- status, out, 8: result of the last command.
- cycle_count, out, CNT_W: enabled pipeline cycles since the last reset.

## Operation
- State codes:
  - INIT=0, IDLE=1, SENDING=2, ARG=3, EXEC=4, SWRESET=5, ACK=6.
- While reset=0:
  - State is INIT, pipelineReset=1, pipelineClkEn=0.
  - rd_uart=0, sendSignal=0, status=0, cycle_count=0, internal counter=0.
- INIT:
  - pipelineClkEn=1 and pipelineReset=1 for RESET_CYCLES cycles, then go to IDLE. Both outputs are 0 in IDLE.
- IDLE:
  - If rx_ready=1, latch r_data as the command and go to ACK.
- ACK:
  - rd_uart=1 for this one cycle. Then dispatch:
  - STEP: counter=1, go to EXEC.
  - RUN: counter=RUN_LIMIT, go to EXEC in run mode.
  - RESET: go to SWRESET.
  - STEPN, first byte: go to ARG.
  - STEPN argument byte: counter=N, go to EXEC. If N=0, go to SENDING with status=8'h00.
  - Any other byte: status=8'hFF, go to SENDING.
- ARG:
  - Wait for rx_ready=1, latch the byte as N, go to ACK (argument pass).
- EXEC:
  - Each cycle the counter is nonzero and program_finished=0: pipelineClkEn=1, counter decrements, cycle_count increments.
  - cycle_count saturates at all-ones.
  - Exit when counter hits 0: status=8'h00, or 8'h02 if in run mode (limit hit).
  - Exit when program_finished=1, sampled before enabling: status=8'h01, and no further enable.
  - On exit go to SENDING.
- SWRESET:
  - pipelineReset=1 and pipelineClkEn=1 for RESET_CYCLES cycles.
  - cycle_count cleared to 0, status=8'h00, then go to SENDING.
- SENDING:
  - sendSignal=1 until dataSent=1 is sampled, then go to IDLE with sendSignal=0.
  - rx_ready is ignored here.

## Timing
- Outputs are registered; status changes on entry to SENDING.
- STEP: command accepted in cycle t (IDLE), rd_uart at t+1, pipelineClkEn=1 at exactly t+2 only, sendSignal from t+3.
- STEPN with N: pipelineClkEn high for N consecutive cycles, fewer if program_finished rises. The count is cut off no later than the cycle after program_finished is seen.
- RUN: at most RUN_LIMIT enabled cycles.
- program_finished=1 when EXEC is entered: zero enabled cycles, status=8'h01.
- Simultaneous dataSent and rx_ready in SENDING: return to IDLE; the byte is handled on the next IDLE cycle.
- Asynchronous reset mid-command: immediately INIT values. Any pending command is lost and the FIFO is not popped.

## Test plan
- Release reset: pipelineReset=1 and pipelineClkEn=1 for 2 cycles, then state=1 with all outputs 0 and cycle_count=0.
- Byte 8'h31: rd_uart single pulse, exactly 1 pipelineClkEn cycle, cycle_count=1, status=8'h00, sendSignal held until dataSent, then state=1.
- Bytes 8'h34, 8'h05: two rd_uart pulses, 5 contiguous enable cycles, cycle_count +5. With N=8'h00: no enable, status=8'h00.
- 8'h32 with program_finished raised after 10 enabled cycles: status=8'h01 and cycle_count=10. With it never raised: exactly RUN_LIMIT cycles and status=8'h02.
- 8'h33 after steps: 2 cycles of pipelineReset=1 with enable, cycle_count=0, dump sent.
- Byte 8'h41: no enable, status=8'hFF, dump sent. Reset asserted mid-RUN: outputs return to INIT values immediately.
